wb_dpbram_arbiter: RTL and testbench



---
 rtl/wb_dpbram_arbiter_pkg.sv | 26 ++
 rtl/wb_dpbram_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_dpbram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dpbram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_dpbram_arbiter_pkg
//   Shared definitions for the two-master Wishbone arbiter in front of the
//   dual-port BRAM: default widths, grant FSM encoding and burst counter size.
// ---------------------------------------------------------------------------
package wb_dpbram_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_MAX_BURST  = 8;

  // MAX_BURST is limited to 1..255, so eight bits always hold the count.
  localparam int BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Ownership state for a given master index.
  function automatic arb_state_e own_state(input logic master);
    return master ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/wb_dpbram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_dpbram_arbiter
//   Arbitrates two pipelined Wishbone masters onto an external dual-port
//   BRAM. Writes use port A, reads use port B (1-cycle read latency).
//   The owning master keeps the grant until it drops cyc, or until it has
//   had MAX_BURST requests accepted while the other master is waiting.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mX_cyc/stb/we         master X Wishbone control
//   i_mX_addr, i_mX_data    master X word address and write data
//   o_mX_stall, o_mX_ack    master X stall (combinational) and ack (registered)
//   o_data                  shared read data, valid with the asserting ack
//   o_enA/o_weA/o_addrA/o_dinA   BRAM write port
//   o_enB/o_addrB, i_doutB       BRAM read port
// ---------------------------------------------------------------------------
module wb_dpbram_arbiter
  import wb_dpbram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  output logic                  o_m0_stall,
  output logic                  o_m0_ack,

  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  output logic                  o_m1_stall,
  output logic                  o_m1_ack,

  output logic [DATA_WIDTH-1:0] o_data,

  output logic                  o_enA,
  output logic                  o_weA,
  output logic [ADDR_WIDTH-1:0] o_addrA,
  output logic [DATA_WIDTH-1:0] o_dinA,

  output logic                  o_enB,
  output logic [ADDR_WIDTH-1:0] o_addrB,
  input  logic [DATA_WIDTH-1:0] i_doutB
);

  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

  arb_state_e             state_q, state_d;
  logic                   last_owner_q, last_owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   ack_q, ack_d;
  logic                   ack_owner_q, ack_owner_d;

  // Owner-side view of the bus; sel1 picks master 1's inputs when it owns.
  logic                  owned, sel1;
  logic                  cyc_own, stb_own, we_own, cyc_oth;
  logic [ADDR_WIDTH-1:0] addr_own;
  logic [DATA_WIDTH-1:0] data_own;
  logic                  at_limit, handoff_stall, accept;

  always_comb begin
    sel1     = (state_q == ST_OWN1);
    owned    = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    cyc_own  = sel1 ? i_m1_cyc  : i_m0_cyc;
    stb_own  = sel1 ? i_m1_stb  : i_m0_stb;
    we_own   = sel1 ? i_m1_we   : i_m0_we;
    addr_own = sel1 ? i_m1_addr : i_m0_addr;
    data_own = sel1 ? i_m1_data : i_m0_data;
    cyc_oth  = sel1 ? i_m0_cyc  : i_m1_cyc;
    at_limit = (burst_cnt_q == MAX_CNT);
    // The owner is held off only when it has used its quota and the other
    // master is actually waiting; otherwise it keeps streaming.
    handoff_stall = owned && at_limit && cyc_oth;
    accept        = owned && cyc_own && stb_own && !handoff_stall;
  end

  // ---------------- state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      ack_q        <= 1'b0;
      ack_owner_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      ack_q        <= ack_d;
      ack_owner_q  <= ack_owner_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          state_d = own_state(!last_owner_q);
        end else if (i_m0_cyc) begin
          state_d = ST_OWN0;
        end else if (i_m1_cyc) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // Release and forced handoff share one path: in the forced case
        // cyc_oth is high, so the grant always moves to the other master.
        if (!cyc_own || (at_limit && cyc_oth)) begin
          last_owner_d = sel1;
          state_d      = cyc_oth ? own_state(!sel1) : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      burst_cnt_d = '0;
    end else if (accept && !at_limit) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end

    ack_d       = accept;
    ack_owner_d = sel1;
  end

  // ---------------- outputs ----------------
  always_comb begin
    o_m0_stall = (state_q != ST_OWN0) || handoff_stall;
    o_m1_stall = (state_q != ST_OWN1) || handoff_stall;

    o_enA   = accept && we_own;
    o_weA   = accept && we_own;
    o_addrA = addr_own;
    o_dinA  = data_own;
    o_enB   = accept && !we_own;
    o_addrB = addr_own;

    // An ack is dropped if its master abandoned the cycle meanwhile.
    o_m0_ack = ack_q && !ack_owner_q && i_m0_cyc;
    o_m1_ack = ack_q &&  ack_owner_q && i_m1_cyc;
    o_data   = i_doutB;
  end

endmodule

// File: tb/tb_wb_dpbram_arbiter.sv
module tb_wb_dpbram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_data = '0;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_data = '0;
  logic          m0_stall, m0_ack, m1_stall, m1_ack;
  logic [DW-1:0] rdata;
  logic          enA, weA, enB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, doutB;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] bram      [0:(1<<AW)-1];

  wb_dpbram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
    .i_m0_addr(m0_addr), .i_m0_data(m0_data),
    .o_m0_stall(m0_stall), .o_m0_ack(m0_ack),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
    .i_m1_addr(m1_addr), .i_m1_data(m1_data),
    .o_m1_stall(m1_stall), .o_m1_ack(m1_ack),
    .o_data(rdata),
    .o_enA(enA), .o_weA(weA), .o_addrA(addrA), .o_dinA(dinA),
    .o_enB(enB), .o_addrB(addrB), .i_doutB(doutB)
  );

  // Simple dual-port BRAM stand-in: 1-cycle registered read, no reset.
  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      bram[i] = '0;
      model_mem[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (enA && weA) bram[addrA] <= dinA;
    if (enB) doutB <= bram[addrB];
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (rst_n && (m0_ack || m1_ack))
      $display("txn ack m%0d data=%08h", m1_ack ? 1 : 0, rdata);
  end

  // Drive one cycle of master inputs just after the edge, then let the
  // combinational outputs settle; the caller samples right after.
  task automatic drive(input logic c0, s0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic c1, s1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(posedge clk); #1;
    m0_cyc = c0; m0_stb = s0; m0_we = w0; m0_addr = a0; m0_data = d0;
    m1_cyc = c1; m1_stb = s1; m1_we = w1; m1_addr = a1; m1_data = d1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (m0_stall !== 1'b1 || m1_stall !== 1'b1) begin errors++;
      $display("FAIL reset_stall: got %b%b expected 11", m0_stall, m1_stall); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++;
      $display("FAIL reset_ack: got %b%b expected 00", m0_ack, m1_ack); end
    checks++; if (enA !== 1'b0 || enB !== 1'b0) begin errors++;
      $display("FAIL reset_en: got %b%b expected 00", enA, enB); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1, 1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 0, '0, '0);            // t0 (IDLE)
    checks++; if (m0_stall !== 1'b1 || enA !== 1'b0) begin errors++;
      $display("FAIL wr_t0: stall=%b enA=%b expected 1 0", m0_stall, enA); end
    drive(1, 1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 0, '0, '0);            // t1 accept
    checks++; if (m0_stall !== 1'b0 || enA !== 1'b1 || weA !== 1'b1 ||
                  addrA !== 10'd5 || dinA !== 32'hDEADBEEF || enB !== 1'b0) begin errors++;
      $display("FAIL wr_t1: stall=%b enA=%b weA=%b addr=%0d din=%08h expected 0 1 1 5 deadbeef",
               m0_stall, enA, weA, addrA, dinA); end
    model_mem[5] = 32'hDEADBEEF;
    drive(1, 0, 0, 10'd5, '0, 0, 0, 0, '0, '0);                      // t2 ack
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++;
      $display("FAIL wr_ack: got m0=%b m1=%b expected 1 0", m0_ack, m1_ack); end
    drive(1, 1, 0, 10'd5, '0, 0, 0, 0, '0, '0);                      // read accept
    checks++; if (enB !== 1'b1 || addrB !== 10'd5 || enA !== 1'b0) begin errors++;
      $display("FAIL rd_accept: enB=%b addrB=%0d enA=%b expected 1 5 0", enB, addrB, enA); end
    drive(1, 0, 0, 10'd5, '0, 0, 0, 0, '0, '0);
    checks++; if (m0_ack !== 1'b1 || rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_ack: ack=%b data=%08h expected 1 deadbeef", m0_ack, rdata); end
    idle(2);
  endtask

  task automatic test_grant();
    reset_pulse();
    drive(1, 0, 0, '0, '0, 1, 0, 0, '0, '0);
    checks++; if (m0_stall !== 1'b1 || m1_stall !== 1'b1) begin errors++;
      $display("FAIL grant_idle: got %b%b expected 11", m0_stall, m1_stall); end
    drive(1, 0, 0, '0, '0, 1, 0, 0, '0, '0);
    checks++; if (m0_stall !== 1'b0 || m1_stall !== 1'b1) begin errors++;
      $display("FAIL grant_own0: got %b%b expected 01", m0_stall, m1_stall); end
    drive(0, 0, 0, '0, '0, 1, 0, 0, '0, '0);
    drive(0, 0, 0, '0, '0, 1, 0, 0, '0, '0);
    checks++; if (m0_stall !== 1'b1 || m1_stall !== 1'b0) begin errors++;
      $display("FAIL grant_own1: got %b%b expected 10", m0_stall, m1_stall); end
    idle(2);
  endtask

  task automatic test_stream_writes();
    int issued = 0, acq = -1, acks = 0, first_ack = -1, last_ack = -1, stalls = 0, wr_en = 0;
    logic [DW-1:0] d;
    for (int c = 0; c < 16; c++) begin
      d = $urandom;
      drive(1, issued < 10, 1, AW'(100 + issued), d, 0, 0, 0, '0, '0);
      if (m0_ack) begin acks++; if (first_ack < 0) first_ack = c; last_ack = c; end
      if (acq < 0 && !m0_stall) acq = c;
      if (acq >= 0 && issued < 10 && m0_stall) stalls++;
      if (issued < 10 && !m0_stall) begin
        if (enA && weA && addrA == AW'(100 + issued) && dinA == d) wr_en++;
        model_mem[100 + issued] = d;
        issued++;
      end
    end
    checks++; if (acq !== 1) begin errors++;
      $display("FAIL stream_acq: got cycle %0d expected 1", acq); end
    checks++; if (stalls !== 0) begin errors++;
      $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    checks++; if (wr_en !== 10) begin errors++;
      $display("FAIL stream_porta: got %0d writes expected 10", wr_en); end
    checks++; if (acks !== 10 || first_ack !== 2 || last_ack !== 11) begin errors++;
      $display("FAIL stream_acks: got %0d acks cycles %0d..%0d expected 10 acks cycles 2..11",
               acks, first_ack, last_ack); end
    idle(2);
  endtask

  task automatic test_forced_handoff();
    int issued = 0, acq = -1, acks = 0, bad_data = 0;
    logic st0 [0:19];
    logic st1 [0:19];
    logic ak0 [0:19];
    logic [AW-1:0] q [$];
    logic [AW-1:0] ea;
    for (int c = 0; c < 20; c++) begin
      drive(1, issued < 10, 0, AW'(100 + issued), '0, c >= 1, 0, 0, '0, '0);
      st0[c] = m0_stall; st1[c] = m1_stall; ak0[c] = m0_ack;
      if (m0_ack) begin
        acks++;
        if (q.size() == 0) bad_data++;
        else begin ea = q.pop_front(); if (rdata !== model_mem[ea]) bad_data++; end
      end
      if (acq < 0 && !m0_stall) acq = c;
      if (issued < 10 && !m0_stall) begin q.push_back(AW'(100 + issued)); issued++; end
    end
    checks++; if (acq !== 1) begin errors++;
      $display("FAIL burst_acq: got cycle %0d expected 1", acq); end
    if (acq >= 0 && acq <= 14) begin
      checks++; if (st0[acq+3] !== 1'b0 || st0[acq+4] !== 1'b1) begin errors++;
        $display("FAIL burst_stall5: got %b%b expected 01", st0[acq+3], st0[acq+4]); end
      checks++; if (st1[acq+5] !== 1'b0) begin errors++;
        $display("FAIL burst_m1_own: got stall=%b expected 0", st1[acq+5]); end
      checks++; if (ak0[acq+4] !== 1'b1 || ak0[acq+5] !== 1'b0) begin errors++;
        $display("FAIL burst_last_ack: got %b%b expected 10", ak0[acq+4], ak0[acq+5]); end
    end
    checks++; if (acks !== MB || bad_data !== 0) begin errors++;
      $display("FAIL burst_acks: got %0d acks %0d bad expected %0d acks 0 bad", acks, bad_data, MB); end
    idle(2);
  endtask

  task automatic test_raw();
    drive(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    drive(1, 1, 1, 10'd7, 32'h1234, 0, 0, 0, '0, '0);
    model_mem[7] = 32'h1234;
    drive(1, 1, 0, 10'd7, '0, 0, 0, 0, '0, '0);
    checks++; if (m0_ack !== 1'b1 || enB !== 1'b1) begin errors++;
      $display("FAIL raw_wr_ack: ack=%b enB=%b expected 1 1", m0_ack, enB); end
    drive(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    checks++; if (m0_ack !== 1'b1 || rdata !== 32'h1234) begin errors++;
      $display("FAIL raw_data: ack=%b data=%08h expected 1 00001234", m0_ack, rdata); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    drive(1, 1, 1, 10'd9, 32'hCAFE0009, 0, 0, 0, '0, '0);
    model_mem[9] = 32'hCAFE0009;
    drive(1, 1, 0, 10'd9, '0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 10'd9, '0, 0, 0, 0, '0, '0);
    checks++; if (m0_ack !== 1'b1) begin errors++;
      $display("FAIL rstmid_pending: ack=%b expected 1", m0_ack); end
    rst_n = 1'b0; #1;
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_stall !== 1'b1 || enB !== 1'b0) begin errors++;
      $display("FAIL rstmid_clear: ack=%b%b stall0=%b enB=%b expected 00 1 0", m0_ack, m1_ack, m0_stall, enB); end
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;
    rst_n = 1'b1;
    idle(1);
    drive(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 10'd9, '0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    checks++; if (m0_ack !== 1'b1 || rdata !== 32'hCAFE0009) begin errors++;
      $display("FAIL rstmid_data: ack=%b data=%08h expected 1 cafe0009", m0_ack, rdata); end
    idle(2);
  endtask

  // Random two-master traffic against a rule-level model of ownership,
  // quota, ack routing/abort and memory contents.
  task automatic test_random();
    int own = -1, last = 1, cnt = 0, pend_m = 0;
    logic pend_v = 0, pend_rd = 0;
    logic [DW-1:0] pend_data = '0;
    logic c0 = 0, c1 = 0, s0, s1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic e_s0, e_s1, e_a0, e_a1, acc, o_c, o_s, o_w, y_c;
    logic [AW-1:0] o_a;
    logic [DW-1:0] o_d;
    reset_pulse();
    for (int c = 0; c < 400; c++) begin
      c0 = c0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      c1 = c1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      s0 = c0 && ($urandom_range(0, 3) != 0); w0 = $urandom_range(0, 1) == 1;
      s1 = c1 && ($urandom_range(0, 3) != 0); w1 = $urandom_range(0, 1) == 1;
      a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
      d0 = $urandom; d1 = $urandom;
      drive(c0, s0, w0, a0, d0, c1, s1, w1, a1, d1);

      e_s0 = (own != 0) || (cnt == MB && c1);
      e_s1 = (own != 1) || (cnt == MB && c0);
      e_a0 = pend_v && pend_m == 0 && c0;
      e_a1 = pend_v && pend_m == 1 && c1;
      checks++; if (m0_stall !== e_s0 || m1_stall !== e_s1) begin errors++;
        $display("FAIL rnd_stall c%0d: got %b%b expected %b%b", c, m0_stall, m1_stall, e_s0, e_s1); end
      checks++; if (m0_ack !== e_a0 || m1_ack !== e_a1) begin errors++;
        $display("FAIL rnd_ack c%0d: got %b%b expected %b%b", c, m0_ack, m1_ack, e_a0, e_a1); end
      if ((e_a0 || e_a1) && pend_rd) begin
        checks++; if (rdata !== pend_data) begin errors++;
          $display("FAIL rnd_data c%0d: got %08h expected %08h", c, rdata, pend_data); end
      end

      o_c = (own == 1) ? c1 : c0; o_s = (own == 1) ? s1 : s0; o_w = (own == 1) ? w1 : w0;
      o_a = (own == 1) ? a1 : a0; o_d = (own == 1) ? d1 : d0; y_c = (own == 1) ? c0 : c1;
      acc = (own >= 0) && o_c && o_s && !((own == 0) ? e_s0 : e_s1);
      checks++; if (enA !== (acc && o_w) || enB !== (acc && !o_w)) begin errors++;
        $display("FAIL rnd_en c%0d: got %b%b expected %b%b", c, enA, enB, acc && o_w, acc && !o_w); end
      if (acc && o_w) begin
        checks++; if (addrA !== o_a || dinA !== o_d || weA !== 1'b1) begin errors++;
          $display("FAIL rnd_porta c%0d: got %0d %08h expected %0d %08h", c, addrA, dinA, o_a, o_d); end
      end
      if (acc && !o_w) begin
        checks++; if (addrB !== o_a) begin errors++;
          $display("FAIL rnd_portb c%0d: got %0d expected %0d", c, addrB, o_a); end
      end

      pend_v = acc; pend_m = own; pend_rd = !o_w;
      pend_data = model_mem[o_a];
      if (acc && o_w) model_mem[o_a] = o_d;

      if (own < 0) begin
        if (c0 && c1) own = (last == 1) ? 0 : 1;
        else if (c0) own = 0;
        else if (c1) own = 1;
        cnt = 0;
      end else if (!o_c || (cnt == MB && y_c)) begin
        last = own;
        own = y_c ? 1 - own : -1;
        cnt = 0;
      end else if (acc && cnt < MB) begin
        cnt++;
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_grant();
    test_stream_writes();
    test_forced_handoff();
    test_raw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
